// File: rtl/bsg_manycore_stat_tag_tracker.sv
// bsg_manycore_stat_tag_tracker: pairs START/END print-stat tags per id and reports elapsed cycles; optional logging via BSG_STAT_TAG_TRACKER_DISPLAY_EN
module bsg_manycore_stat_tag_tracker #(
   parameter int data_width_p = 32,
   parameter int num_tags_p = 16,
   parameter int ctr_width_p = 32,
   localparam int id_width_lp = $clog2(num_tags_p),
   localparam int cnt_width_lp = $clog2(num_tags_p + 1)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    v_i,
   input  logic [data_width_p-1:0] tag_i,
   input  logic [ctr_width_p-1:0]  ctr_i,
   output logic                    done_v_o,
   output logic [id_width_lp-1:0]  done_id_o,
   output logic [ctr_width_p-1:0]  elapsed_o,
   output logic                    mark_v_o,
   output logic                    err_restart_o,
   output logic                    err_unmatched_o,
   output logic [cnt_width_lp-1:0] open_count_o,
   output logic                    idle_o
);
   logic [1:0] typ;
   logic [id_width_lp-1:0] id;
   logic [num_tags_p-1:0] open_r;
   logic [ctr_width_p-1:0] start_r [num_tags_p];
   logic is_open, start_v, end_v, mark_v;
   logic unused_bits;
   assign typ = tag_i[data_width_p-1 -: 2];
   assign id = tag_i[id_width_lp-1:0];
   assign unused_bits = ^tag_i[data_width_p-3:id_width_lp];
   assign is_open = open_r[id];
   assign start_v = v_i & (typ == 2'd0);
   assign end_v = v_i & (typ == 2'd1);
   assign mark_v = v_i & (typ == 2'd2);
   assign idle_o = (open_count_o == '0);
   // per-id open bits, open count and registered result/pulse outputs
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         open_r <= '0;
         open_count_o <= '0;
         done_v_o <= 1'b0;
         done_id_o <= '0;
         elapsed_o <= '0;
         mark_v_o <= 1'b0;
         err_restart_o <= 1'b0;
         err_unmatched_o <= 1'b0;
      end else begin
         done_v_o <= end_v & is_open;
         mark_v_o <= mark_v;
         err_restart_o <= start_v & is_open;
         err_unmatched_o <= end_v & ~is_open;
         if (start_v) begin
            open_r[id] <= 1'b1;
            if (!is_open) open_count_o <= open_count_o + cnt_width_lp'(1);
         end
         if (end_v && is_open) begin
            open_r[id] <= 1'b0;
            open_count_o <= open_count_o - cnt_width_lp'(1);
            done_id_o <= id;
            elapsed_o <= ctr_i - start_r[id];
         end
      end
   end
   // start counters need no reset: they are only read while their open bit is set
   always_ff @(posedge clk_i) begin
      if (start_v) start_r[id] <= ctr_i;
   end
`ifdef BSG_STAT_TAG_TRACKER_DISPLAY_EN
   // log completions and protocol errors on the edge that registers their pulse
   always_ff @(posedge clk_i) begin
      if (!reset_i && end_v && is_open) $display("[STAT] id=%0d elapsed=%0d", id, ctr_i - start_r[id]);
      if (!reset_i && start_v && is_open) $display("[STAT][ERR] restart id=%0d", id);
      if (!reset_i && end_v && !is_open) $display("[STAT][ERR] unmatched id=%0d", id);
   end
`else
`endif
endmodule

// File: tb/tb_bsg_manycore_stat_tag_tracker.sv
// tb_bsg_manycore_stat_tag_tracker: directed and randomized checks against a per-id region model
module tb_bsg_manycore_stat_tag_tracker;
   logic clk_i = 1'b0;
   logic reset_i = 1'b1;
   logic v_i = 1'b0;
   logic [31:0] tag_i = '0;
   logic [31:0] ctr_i = '0;
   logic done_v_o, mark_v_o, err_restart_o, err_unmatched_o, idle_o;
   logic [3:0] done_id_o;
   logic [31:0] elapsed_o;
   logic [4:0] open_count_o;
   int checks = 0;
   int errors = 0;
   bit open_m [16];
   logic [31:0] start_m [16];
   bit exp_done, exp_mark, exp_rs, exp_un;
   logic [3:0] exp_id;
   logic [31:0] exp_el;
   int exp_cnt;

   bsg_manycore_stat_tag_tracker dut (
      .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .tag_i(tag_i), .ctr_i(ctr_i),
      .done_v_o(done_v_o), .done_id_o(done_id_o), .elapsed_o(elapsed_o),
      .mark_v_o(mark_v_o), .err_restart_o(err_restart_o), .err_unmatched_o(err_unmatched_o),
      .open_count_o(open_count_o), .idle_o(idle_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic reset_model();
      foreach (open_m[i]) open_m[i] = 1'b0;
      {exp_done, exp_mark, exp_rs, exp_un} = '0;
      exp_id = '0;
      exp_el = '0;
      exp_cnt = 0;
   endtask

   task automatic drive(input bit v, input logic [31:0] tag, input logic [31:0] ctr);
      int id;
      @(negedge clk_i);
      v_i = v;
      tag_i = tag;
      ctr_i = ctr;
      id = int'(tag[3:0]);
      {exp_done, exp_mark, exp_rs, exp_un} = '0;
      if (v) begin
         case (tag[31:30])
            2'd0: begin exp_rs = open_m[id]; open_m[id] = 1'b1; start_m[id] = ctr; end
            2'd1: if (open_m[id]) begin
                     exp_done = 1'b1; exp_id = tag[3:0]; exp_el = ctr - start_m[id]; open_m[id] = 1'b0;
                  end else exp_un = 1'b1;
            2'd2: exp_mark = 1'b1;
            default: ;
         endcase
      end
      exp_cnt = 0;
      foreach (open_m[i]) exp_cnt += int'(open_m[i]);
      @(posedge clk_i);
      #1;
      v_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
      reset_model();
      #1;
      checks++; if ({done_v_o, mark_v_o, err_restart_o, err_unmatched_o} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {done_v_o, mark_v_o, err_restart_o, err_unmatched_o}); end
      checks++; if (done_id_o !== 4'd0 || elapsed_o !== 32'd0) begin errors++; $display("FAIL reset_data got id=%0d el=%0d exp 0 0", done_id_o, elapsed_o); end
      checks++; if (open_count_o !== 5'd0 || idle_o !== 1'b1) begin errors++; $display("FAIL reset_count got cnt=%0d idle=%b exp 0 1", open_count_o, idle_o); end
   endtask

   task automatic test_basic();
      drive(1, 32'h0000_0003, 32'd100);
      checks++; if (open_count_o !== 5'd1 || idle_o !== 1'b0 || done_v_o !== 1'b0) begin errors++; $display("FAIL basic_start got cnt=%0d idle=%b done=%b exp 1 0 0", open_count_o, idle_o, done_v_o); end
      drive(1, 32'h4000_0003, 32'd350);
      checks++; if (done_v_o !== 1'b1 || done_id_o !== 4'd3 || elapsed_o !== 32'd250) begin errors++; $display("FAIL basic_end got done=%b id=%0d el=%0d exp 1 3 250", done_v_o, done_id_o, elapsed_o); end
      checks++; if (open_count_o !== 5'd0 || idle_o !== 1'b1) begin errors++; $display("FAIL basic_count got cnt=%0d idle=%b exp 0 1", open_count_o, idle_o); end
      drive(0, 32'h4000_0003, 32'd351);
      checks++; if (done_v_o !== 1'b0 || done_id_o !== 4'd3 || elapsed_o !== 32'd250) begin errors++; $display("FAIL basic_hold got done=%b id=%0d el=%0d exp 0 3 250", done_v_o, done_id_o, elapsed_o); end
   endtask

   task automatic test_wrap();
      drive(1, 32'h0000_0000, 32'hFFFF_FFF0);
      drive(1, 32'h4000_0000, 32'h0000_0010);
      checks++; if (done_v_o !== 1'b1 || done_id_o !== 4'd0 || elapsed_o !== 32'h20) begin errors++; $display("FAIL wrap got done=%b id=%0d el=%0h exp 1 0 20", done_v_o, done_id_o, elapsed_o); end
   endtask

   task automatic test_restart();
      drive(1, 32'h0000_0005, 32'd10);
      checks++; if (err_restart_o !== 1'b0) begin errors++; $display("FAIL restart_first got %b exp 0", err_restart_o); end
      drive(1, 32'h0000_0005, 32'd40);
      checks++; if (err_restart_o !== 1'b1 || open_count_o !== 5'd1) begin errors++; $display("FAIL restart_pulse got err=%b cnt=%0d exp 1 1", err_restart_o, open_count_o); end
      drive(1, 32'h4000_0005, 32'd100);
      checks++; if (err_restart_o !== 1'b0 || done_v_o !== 1'b1 || elapsed_o !== 32'd60) begin errors++; $display("FAIL restart_end got err=%b done=%b el=%0d exp 0 1 60", err_restart_o, done_v_o, elapsed_o); end
   endtask

   task automatic test_unmatched();
      drive(1, 32'h4000_0007, 32'd200);
      checks++; if (err_unmatched_o !== 1'b1 || done_v_o !== 1'b0 || open_count_o !== 5'd0) begin errors++; $display("FAIL unmatched got err=%b done=%b cnt=%0d exp 1 0 0", err_unmatched_o, done_v_o, open_count_o); end
   endtask

   task automatic test_back_to_back();
      drive(1, 32'h0000_0001, 32'd5);
      drive(1, 32'h0000_0002, 32'd6);
      drive(1, 32'h0000_000F, 32'd7);
      checks++; if (open_count_o !== 5'd3) begin errors++; $display("FAIL b2b_count got %0d exp 3", open_count_o); end
      drive(1, 32'h4000_0002, 32'd20);
      checks++; if (done_v_o !== 1'b1 || done_id_o !== 4'd2 || elapsed_o !== 32'd14) begin errors++; $display("FAIL b2b_end2 got done=%b id=%0d el=%0d exp 1 2 14", done_v_o, done_id_o, elapsed_o); end
      drive(1, 32'h4000_0001, 32'd21);
      checks++; if (done_v_o !== 1'b1 || done_id_o !== 4'd1 || elapsed_o !== 32'd16) begin errors++; $display("FAIL b2b_end1 got done=%b id=%0d el=%0d exp 1 1 16", done_v_o, done_id_o, elapsed_o); end
      drive(1, 32'h4000_000F, 32'd22);
      checks++; if (done_v_o !== 1'b1 || done_id_o !== 4'd15 || elapsed_o !== 32'd15 || open_count_o !== 5'd0) begin errors++; $display("FAIL b2b_end15 got done=%b id=%0d el=%0d cnt=%0d exp 1 15 15 0", done_v_o, done_id_o, elapsed_o, open_count_o); end
      drive(1, 32'h0000_0009, 32'd30);
      drive(1, 32'h4000_0009, 32'd31);
      checks++; if (done_v_o !== 1'b1 || done_id_o !== 4'd9 || elapsed_o !== 32'd1) begin errors++; $display("FAIL b2b_same got done=%b id=%0d el=%0d exp 1 9 1", done_v_o, done_id_o, elapsed_o); end
   endtask

   task automatic test_reset_mid();
      drive(1, 32'h0000_0004, 32'd500);
      checks++; if (open_count_o !== 5'd1) begin errors++; $display("FAIL mid_open got %0d exp 1", open_count_o); end
      @(negedge clk_i);
      reset_i = 1'b1;
      #1;
      checks++; if (open_count_o !== 5'd0 || idle_o !== 1'b1 || done_id_o !== 4'd0) begin errors++; $display("FAIL mid_async got cnt=%0d idle=%b id=%0d exp 0 1 0", open_count_o, idle_o, done_id_o); end
      reset_model();
      @(negedge clk_i);
      reset_i = 1'b0;
      drive(1, 32'h4000_0004, 32'd520);
      checks++; if (err_unmatched_o !== 1'b1 || done_v_o !== 1'b0) begin errors++; $display("FAIL mid_end got err=%b done=%b exp 1 0", err_unmatched_o, done_v_o); end
      drive(1, 32'h8000_0000, 32'd521);
      checks++; if ({mark_v_o, done_v_o, err_restart_o, err_unmatched_o, open_count_o} !== {4'b1000, 5'd0}) begin errors++; $display("FAIL mark got %b exp 100000000", {mark_v_o, done_v_o, err_restart_o, err_unmatched_o, open_count_o}); end
      drive(1, 32'hC000_0003, 32'd522);
      checks++; if ({mark_v_o, done_v_o, err_restart_o, err_unmatched_o, open_count_o} !== 9'b0) begin errors++; $display("FAIL reserved got %b exp 000000000", {mark_v_o, done_v_o, err_restart_o, err_unmatched_o, open_count_o}); end
   endtask

   task automatic test_random();
      logic [31:0] ctr = 32'hFFFF_FF00;
      logic [45:0] got, exp;
      for (int n = 0; n < 400; n++) begin
         ctr = ($urandom_range(0, 19) == 0) ? $urandom : ctr + 32'd1;
         drive($urandom_range(0, 4) != 0, {2'($urandom_range(0, 3)), 26'($urandom), 4'($urandom_range(0, 15))}, ctr);
         got = {done_v_o, done_id_o, elapsed_o, mark_v_o, err_restart_o, err_unmatched_o, open_count_o, idle_o};
         exp = {exp_done, exp_id, exp_el, exp_mark, exp_rs, exp_un, 5'(exp_cnt), exp_cnt == 0};
         checks++; if (got !== exp) begin errors++; $display("FAIL random[%0d] got %h exp %h", n, got, exp); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_restart();
      test_unmatched();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
